m68k_bram_bus_slave: RTL and testbench

//  Bus slave controller for the WF68K30L asynchronous bus: decodes ASn/DSn/RWn/SIZE/ADR.

---
 rtl/m68k_bus_pkg.sv | 35 +++
 rtl/m68k_bram_bus_slave_if.sv | 18 +
 rtl/m68k_bram.sv | 29 ++
 rtl/m68k_bram_bus_slave.sv | 146 ++++++++++++++
 tb/tb_m68k_bram_bus_slave.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared codes for the 68030-style bus slave: SIZE and DSACK encodings,
// FSM states and the byte-lane mask helper.
package m68k_bus_pkg;

   localparam logic [1:0] SZ_LONG  = 2'b00;
   localparam logic [1:0] SZ_BYTE  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_3BYTE = 2'b11;

   localparam logic [1:0] DSACK_32   = 2'b00;
   localparam logic [1:0] DSACK_NONE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WAIT,
      ST_ACK,
      ST_ERR
   } state_e;

   // Lanes off..off+n-1, clamped at lane 3; a misaligned transfer never wraps to lane 0.
   function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] size);
      logic [2:0] n;
      logic [2:0] last;
      logic [3:0] m;
      n    = (size == SZ_LONG) ? 3'd4 : {1'b0, size};
      last = {1'b0, off} + n - 3'd1;
      if (last > 3'd3) last = 3'd3;
      m = '0;
      for (int k = 0; k < 4; k++)
         m[k] = (3'(k) >= {1'b0, off}) && (3'(k) <= last);
      return m;
   endfunction

endpackage

// File: rtl/m68k_bram_bus_slave_if.sv
// Asynchronous CPU bus bundle between the WF68K30L core (master) and a memory slave.
interface m68k_bram_bus_slave_if;
   logic [31:0] ADR_IN;
   logic [31:0] WDATA;
   logic [31:0] RDATA;
   logic [1:0]  SIZE;
   logic        ASn;
   logic        DSn;
   logic        RWn;
   logic [1:0]  DSACKn;
   logic        BERRn;
   logic        BUSY;

   modport master (output ADR_IN, WDATA, SIZE, ASn, DSn, RWn,
                   input  RDATA, DSACKn, BERRn, BUSY);
   modport slave  (input  ADR_IN, WDATA, SIZE, ASn, DSn, RWn,
                   output RDATA, DSACKn, BERRn, BUSY);
endinterface

// File: rtl/m68k_bram.sv
// Synchronous 32-bit RAM with four byte write enables and a registered read port.
// Lane k (bits [31-8k -: 8]) is byte offset k within the long word.
module m68k_bram #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          re_i,
   input  logic [AW-1:0] addr_i,
   input  logic [3:0]    we_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);
   logic [31:0] mem_q [2**AW];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++)
         if (we_i[k]) mem_q[addr_i][31-8*k -: 8] <= wdata_i[31-8*k -: 8];
   end

   // Output register only moves on a read, so it stays stable through the ack phase.
   always_ff @(posedge clk) begin
      if (rst)       rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/m68k_bram_bus_slave.sv
// Bus slave for the WF68K30L asynchronous bus in front of an on-chip RAM, acked as a 32-bit port.
// Define BUS_ERROR_EN to answer out-of-window strobes with BERRn instead of ignoring them.
//
//  state  | meaning
//  IDLE   | waiting for a decoded strobe
//  ACCESS | RAM read issued at the latched long address
//  WAIT   | counting programmed wait states
//  ACK    | DSACKn asserted until ASn goes high; write committed on entry
//  ERR    | BERRn asserted until ASn goes high (BUS_ERROR_EN only)
module m68k_bram_bus_slave
   import m68k_bus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          ADDR_BITS   = 10,
   parameter int          WAIT_STATES = 1
) (
   input  logic CLK,
   input  logic RESET,
   m68k_bram_bus_slave_if.slave bus
);
   localparam int AW = ADDR_BITS - 2;

   state_e        state_q;
   logic [3:0]    cnt_q;
   logic [AW-1:0] widx_q;
   logic          rw_q;
   logic [3:0]    lanes_q;
   logic [31:0]   wdata_q;
   logic [1:0]    dsack_q;
   logic          busy_q;
   logic [3:0]    we_q;
   logic [31:0]   ram_rdata;
   logic          start;
   logic          hit;

   assign start = !bus.ASn && (bus.RWn || !bus.DSn);
   assign hit   = bus.ADR_IN[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS];

`ifdef BUS_ERROR_EN
   logic berr_q;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         widx_q  <= '0;
         rw_q    <= 1'b1;
         lanes_q <= '0;
         wdata_q <= '0;
         dsack_q <= DSACK_NONE;
         busy_q  <= 1'b0;
         we_q    <= '0;
`ifdef BUS_ERROR_EN
         berr_q  <= 1'b1;
`endif
      end else begin
         we_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (start && hit) begin
                  state_q <= ST_ACCESS;
                  busy_q  <= 1'b1;
                  widx_q  <= bus.ADR_IN[ADDR_BITS-1:2];
                  rw_q    <= bus.RWn;
                  lanes_q <= lane_mask(bus.ADR_IN[1:0], bus.SIZE);
                  if (!bus.RWn) wdata_q <= bus.WDATA;
               end
`ifdef BUS_ERROR_EN
               else if (start) begin
                  state_q <= ST_ERR;
                  busy_q  <= 1'b1;
                  berr_q  <= 1'b0;
               end
`endif
            end
            ST_ACCESS: begin
               if (bus.ASn) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (WAIT_STATES == 0) begin
                  state_q <= ST_ACK;
                  dsack_q <= DSACK_32;
                  we_q    <= rw_q ? 4'b0000 : lanes_q;
               end else begin
                  state_q <= ST_WAIT;
                  cnt_q   <= 4'(WAIT_STATES);
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (bus.ASn) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end else if (cnt_q == 4'd1) begin
                  state_q <= ST_ACK;
                  dsack_q <= DSACK_32;
                  we_q    <= rw_q ? 4'b0000 : lanes_q;
               end
            end
            ST_ACK: begin
               if (bus.ASn) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  dsack_q <= DSACK_NONE;
               end
            end
`ifdef BUS_ERROR_EN
            ST_ERR: begin
               if (bus.ASn) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  berr_q  <= 1'b1;
               end
            end
`endif
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               dsack_q <= DSACK_NONE;
            end
         endcase
      end
   end

   // Gating with RESET drops a strobe that collides with a reset edge.
   m68k_bram #(.AW(AW)) u_bram (
      .clk     (CLK),
      .rst     (RESET),
      .re_i    (state_q == ST_ACCESS),
      .addr_i  (widx_q),
      .we_i    (we_q & {4{!RESET}}),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   assign bus.RDATA  = ram_rdata;
   assign bus.DSACKn = dsack_q;
   assign bus.BUSY   = busy_q;
`ifdef BUS_ERROR_EN
   assign bus.BERRn  = berr_q;
`else
   assign bus.BERRn  = 1'b1;
`endif
endmodule

// File: tb/tb_m68k_bram_bus_slave.sv
// Self-checking bench for m68k_bram_bus_slave: directed table, corner sequences, random cycles
// checked against a byte-addressed memory model.
module tb_m68k_bram_bus_slave;
   localparam int ABITS = 10;
   localparam int WS    = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [7:0] mdl [1024];

   m68k_bram_bus_slave_if bus();

   m68k_bram_bus_slave #(.BASE_ADDR(32'h0), .ADDR_BITS(ABITS), .WAIT_STATES(WS)) dut (
      .CLK(clk), .RESET(rst), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      int i;
      i = int'(a[ABITS-1:0]) & ~3;
      return {mdl[i], mdl[i+1], mdl[i+2], mdl[i+3]};
   endfunction

   function automatic void m_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      int i, off, n;
      i   = int'(a[ABITS-1:0]) & ~3;
      off = int'(a[1:0]);
      n   = (sz == 2'b00) ? 4 : int'(sz);
      for (int k = off; k < off + n && k < 4; k++) mdl[i+k] = wd[31-8*k -: 8];
   endfunction

   task automatic wait_ack(output int lat);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.DSACKn == 2'b00) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic end_cycle(input logic [31:0] rd);
      @(negedge clk);
      chk("ack_hold", {30'd0, bus.DSACKn}, 32'd0);
      chk("rdata_hold", bus.RDATA, rd);
      bus.ASn = 1'b1;
      bus.DSn = 1'b1;
      @(negedge clk);
      chk("ack_release", {30'd0, bus.DSACKn}, 32'd3);
      chk("busy_release", {31'd0, bus.BUSY}, 32'd0);
   endtask

   task automatic bus_cycle(input logic [31:0] a, input logic [1:0] sz, input logic rw,
                            input logic [31:0] wd, output int lat, output logic [31:0] rd);
      @(negedge clk);
      bus.ADR_IN = a;
      bus.SIZE   = sz;
      bus.RWn    = rw;
      bus.WDATA  = wd;
      bus.ASn    = 1'b0;
      bus.DSn    = rw ? 1'b0 : 1'b1;
      if (!rw) begin
         @(negedge clk);
         bus.DSn = 1'b0;
      end
      wait_ack(lat);
      rd = bus.RDATA;
      end_cycle(rd);
      if (!rw) m_write(a, sz, wd);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [1:0]  sz;
      logic        rw;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int          lat;
      logic [31:0] rd;
      logic [31:0] a;
      logic [1:0]  sz;
      logic        rw;

      vecs[0]  = '{32'h10, 2'b00, 1'b0, 32'h1122_3344, 32'h0};
      vecs[1]  = '{32'h10, 2'b00, 1'b1, 32'h0,         32'h1122_3344};
      vecs[2]  = '{32'h21, 2'b01, 1'b0, 32'h00AB_0000, 32'h0};
      vecs[3]  = '{32'h20, 2'b00, 1'b1, 32'h0,         32'h00AB_0000};
      vecs[4]  = '{32'h23, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0};
      vecs[5]  = '{32'h20, 2'b00, 1'b1, 32'h0,         32'h00AB_00EF};
      vecs[6]  = '{32'h31, 2'b11, 1'b0, 32'hFFCA_FE77, 32'h0};
      vecs[7]  = '{32'h30, 2'b00, 1'b1, 32'h0,         32'h00CA_FE77};
      vecs[8]  = '{32'h12, 2'b01, 1'b0, 32'h0000_AA00, 32'h0};
      vecs[9]  = '{32'h10, 2'b00, 1'b1, 32'h0,         32'h1122_AA44};
      vecs[10] = '{32'h22, 2'b10, 1'b0, 32'h0000_BEEF, 32'h0};
      vecs[11] = '{32'h20, 2'b00, 1'b1, 32'h0,         32'h00AB_BEEF};

      bus.ADR_IN = '0; bus.WDATA = '0; bus.SIZE = 2'b00;
      bus.ASn = 1'b1; bus.DSn = 1'b1; bus.RWn = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_dsack", {30'd0, bus.DSACKn}, 32'd3);
      chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
      chk("rst_rdata", bus.RDATA, 32'd0);
      rst = 1'b0;

      // Clear the whole RAM so the model starts from known zeros.
      for (int w = 0; w < 256; w++) bus_cycle(32'(w * 4), 2'b00, 1'b0, 32'h0, lat, rd);
      for (int i = 0; i < 1024; i++) mdl[i] = 8'h00;

      for (int v = 0; v < 12; v++) begin
         bus_cycle(vecs[v].a, vecs[v].sz, vecs[v].rw, vecs[v].wd, lat, rd);
         chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(WS + 2));
         if (vecs[v].rw) chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp);
      end

      // Reset held with a write strobe pending, then released into a normal cycle.
      @(negedge clk);
      rst = 1'b1;
      bus.ADR_IN = 32'h40; bus.SIZE = 2'b00; bus.RWn = 1'b0; bus.WDATA = 32'h5555_AAAA;
      bus.ASn = 1'b0; bus.DSn = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("inrst_dsack", {30'd0, bus.DSACKn}, 32'd3);
         chk("inrst_busy", {31'd0, bus.BUSY}, 32'd0);
         chk("inrst_berr", {31'd0, bus.BERRn}, 32'd1);
         chk("inrst_rdata", bus.RDATA, 32'd0);
      end
      rst = 1'b0;
      wait_ack(lat);
      chk("post_rst_lat", 32'(lat), 32'(WS + 2));
      end_cycle(bus.RDATA);
      m_write(32'h40, 2'b00, 32'h5555_AAAA);
      bus_cycle(32'h40, 2'b00, 1'b1, 32'h0, lat, rd);
      chk("post_rst_rdata", rd, m_read(32'h40));

      // Reset while waiting: pending write must be dropped.
      @(negedge clk);
      bus.ADR_IN = 32'h44; bus.RWn = 1'b0; bus.WDATA = 32'h1234_5678; bus.SIZE = 2'b00;
      bus.ASn = 1'b0; bus.DSn = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1; bus.ASn = 1'b1; bus.DSn = 1'b1;
      @(negedge clk);
      chk("midrst_busy", {31'd0, bus.BUSY}, 32'd0);
      chk("midrst_dsack", {30'd0, bus.DSACKn}, 32'd3);
      rst = 1'b0;
      bus_cycle(32'h44, 2'b00, 1'b1, 32'h0, lat, rd);
      chk("midrst_rdata", rd, m_read(32'h44));

      // Write with DSn late by two clocks.
      @(negedge clk);
      bus.ADR_IN = 32'h60; bus.RWn = 1'b0; bus.WDATA = 32'hA5A5_5A5A; bus.SIZE = 2'b00;
      bus.ASn = 1'b0; bus.DSn = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("dsn_wait_dsack", {30'd0, bus.DSACKn}, 32'd3);
         chk("dsn_wait_busy", {31'd0, bus.BUSY}, 32'd0);
      end
      bus.DSn = 1'b0;
      wait_ack(lat);
      chk("dsn_late_lat", 32'(lat), 32'(WS + 2));
      end_cycle(bus.RDATA);
      m_write(32'h60, 2'b00, 32'hA5A5_5A5A);
      bus_cycle(32'h60, 2'b00, 1'b1, 32'h0, lat, rd);
      chk("dsn_late_rdata", rd, m_read(32'h60));

      // Abort during WAIT: no ack, no write.
      @(negedge clk);
      bus.ADR_IN = 32'h50; bus.RWn = 1'b0; bus.WDATA = 32'hFFFF_FFFF; bus.SIZE = 2'b00;
      bus.ASn = 1'b0; bus.DSn = 1'b0;
      repeat (2) @(negedge clk);
      bus.ASn = 1'b1; bus.DSn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("abort_dsack", {30'd0, bus.DSACKn}, 32'd3);
         chk("abort_busy", {31'd0, bus.BUSY}, 32'd0);
      end
      bus_cycle(32'h50, 2'b00, 1'b1, 32'h0, lat, rd);
      chk("abort_rdata", rd, m_read(32'h50));

      // Strobe just above the window.
      @(negedge clk);
      bus.ADR_IN = 32'h400; bus.RWn = 1'b1; bus.SIZE = 2'b00;
      bus.ASn = 1'b0; bus.DSn = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("oow_dsack", {30'd0, bus.DSACKn}, 32'd3);
`ifdef BUS_ERROR_EN
         chk("oow_berr", {31'd0, bus.BERRn}, 32'd0);
`else
         chk("oow_berr", {31'd0, bus.BERRn}, 32'd1);
         chk("oow_busy", {31'd0, bus.BUSY}, 32'd0);
`endif
      end
      bus.ASn = 1'b1; bus.DSn = 1'b1;
      @(negedge clk);
      chk("oow_berr_release", {31'd0, bus.BERRn}, 32'd1);
      chk("oow_busy_release", {31'd0, bus.BUSY}, 32'd0);

      // Random traffic against the byte model.
      for (int r = 0; r < 60; r++) begin
         a  = 32'($urandom_range(0, 1023));
         sz = 2'($urandom_range(0, 3));
         rw = 1'($urandom_range(0, 1));
         bus_cycle(a, sz, rw, $urandom, lat, rd);
         chk("rnd_lat", 32'(lat), 32'(WS + 2));
         if (rw) chk($sformatf("rnd_rdata@%h", a), rd, m_read(a));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
